// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a shared single memory port. A requester can lock
// the grant for an atomic sequence; the lock is force-released after LOCK_MAX transfers.
module mem_port_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_we,
  input  logic [NREQ-1:0]   i_lock,
  input  logic [NREQ*9-1:0] i_addr,
  input  logic [NREQ*32-1:0] i_wdata,
  input  logic [NREQ*4-1:0] i_bmask,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_rvalid,
  output logic [31:0]       o_rdata,
  output logic [8:0]        o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [PW-1:0]   scan_idx;
  logic            scan_found;
  logic [PW-1:0]   xfer_idx;
  logic            xfer;
  int unsigned     sel;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (32'(p) == NREQ - 1) return '0;
    return p + PW'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic [PW-1:0] idx;
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(rr_ptr_q) + i) % NREQ);
      if (!scan_found && i_req[idx]) begin
        scan_found = 1'b1;
        scan_idx   = idx;
      end
    end
  end

  always_comb begin
    o_gnt    = '0;
    xfer_idx = (state_q == ST_LOCKED) ? owner_q : scan_idx;
    if (!i_reset) begin
      if (state_q == ST_LOCKED) o_gnt[owner_q] = i_req[owner_q];
      else if (scan_found)      o_gnt[scan_idx] = 1'b1;
    end
    xfer = |o_gnt;
    sel  = 32'(xfer_idx);
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    o_mem_wren  = 1'b0;
    if (xfer) begin
      o_mem_addr  = i_addr[sel*9 +: 9];
      o_mem_wdata = i_wdata[sel*32 +: 32];
      o_mem_bmask = i_bmask[sel*4 +: 4];
      o_mem_wren  = i_we[xfer_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;

    if (xfer && !i_we[xfer_idx]) begin
      rvalid_d = o_gnt;
      rdata_d  = i_mem_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          rr_ptr_d = next_ptr(scan_idx);
          // With LOCK_MAX of 1 the first locked transfer is also the last.
          if (i_lock[scan_idx] && LOCK_MAX > 1) begin
            state_d    = ST_LOCKED;
            owner_d    = scan_idx;
            lock_cnt_d = CW'(1);
          end
        end
      end
      default: begin
        if (i_req[owner_q]) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
          if (!i_lock[owner_q] || lock_cnt_d == CW'(LOCK_MAX)) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = next_ptr(owner_q);
            lock_cnt_d = '0;
          end
        end else if (!i_lock[owner_q]) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = next_ptr(owner_q);
          lock_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for arbitration and read
// latency, hand-written sequences for locking, forced release and reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        i_reset;
  logic [2:0]  i_req, i_we, i_lock;
  logic [26:0] i_addr;
  logic [95:0] i_wdata;
  logic [11:0] i_bmask;
  logic [2:0]  o_gnt, o_rvalid;
  logic [31:0] o_rdata, o_mem_wdata, mem_rdata;
  logic [8:0]  o_mem_addr;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;

  logic [31:0] mem [512];

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.NREQ(3), .LOCK_MAX(8)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_lock     (i_lock),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_bmask    (i_bmask),
    .o_gnt      (o_gnt),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask),
    .o_mem_wren (o_mem_wren),
    .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word i preloaded with 0x10000000+i, byte-masked writes.
  assign mem_rdata = mem[o_mem_addr];
  always @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_bmask[b]) mem[o_mem_addr][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic step(input string nm, input logic [2:0] req, input logic [2:0] we,
                      input logic [2:0] lock, input logic [2:0] exp_gnt, input logic exp_wren,
                      input logic [2:0] exp_rv, input logic [31:0] exp_rd);
    i_req = req; i_we = we; i_lock = lock;
    #1;
    chk({nm, " gnt"}, 32'(o_gnt), 32'(exp_gnt));
    chk({nm, " wren"}, 32'(o_mem_wren), 32'(exp_wren));
    @(posedge clk); #1;
    chk({nm, " rvalid"}, 32'(o_rvalid), 32'(exp_rv));
    chk({nm, " rdata"}, o_rdata, exp_rd);
    @(negedge clk);
  endtask

  task automatic default_slices();
    i_addr  = {9'd12, 9'd11, 9'd10};
    i_wdata = {32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};
    i_bmask = 12'hFFF;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  gnt;
    logic        wren;
    logic [2:0]  rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{3'b111, 3'b000, 3'b001, 1'b0, 3'b001, 32'h1000_000A};
    tbl[1]  = '{3'b111, 3'b000, 3'b010, 1'b0, 3'b010, 32'h1000_000B};
    tbl[2]  = '{3'b111, 3'b000, 3'b100, 1'b0, 3'b100, 32'h1000_000C};
    for (int i = 3; i < 8; i++)
      tbl[i] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 32'h1000_000C};
    tbl[8]  = '{3'b110, 3'b000, 3'b010, 1'b0, 3'b010, 32'h1000_000B};
    tbl[9]  = '{3'b011, 3'b000, 3'b001, 1'b0, 3'b001, 32'h1000_000A};
    tbl[10] = '{3'b101, 3'b100, 3'b100, 1'b1, 3'b000, 32'h1000_000A};

    i_reset = 1'b1; i_req = '0; i_we = '0; i_lock = '0;
    default_slices();
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_req = 3'b111;
    #1 chk("reset gnt", 32'(o_gnt), 32'h0);
    i_req = '0;
    i_reset = 1'b0;
    chk("reset rvalid", 32'(o_rvalid), 32'h0);
    chk("reset rdata", o_rdata, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].we, 3'b000,
           tbl[i].gnt, tbl[i].wren, tbl[i].rv, tbl[i].rd);

    // Partial write by req0 then read-back by req1 of the same word.
    i_addr[0 +: 9] = 9'd5; i_addr[9 +: 9] = 9'd5;
    i_wdata[0 +: 32] = 32'hAABB_CCDD; i_bmask[0 +: 4] = 4'b0011;
    i_req = 3'b001; i_we = 3'b001; i_lock = '0;
    #1;
    chk("wr addr", 32'(o_mem_addr), 32'd5);
    chk("wr bmask", 32'(o_mem_bmask), 32'h3);
    step("wr0", 3'b001, 3'b001, 3'b000, 3'b001, 1'b1, 3'b000, 32'h1000_000A);
    step("rd1", 3'b010, 3'b000, 3'b000, 3'b010, 1'b0, 3'b010, 32'h1000_CCDD);
    default_slices();

    // Req1 lock held against competing requests until forced release.
    step("lk1 first", 3'b010, 3'b000, 3'b010, 3'b010, 1'b0, 3'b010, 32'h1000_000B);
    for (int i = 0; i < 7; i++)
      step($sformatf("lk1 hold%0d", i), 3'b111, 3'b000, 3'b010, 3'b010, 1'b0, 3'b010, 32'h1000_000B);
    step("lk1 released", 3'b111, 3'b000, 3'b010, 3'b100, 1'b0, 3'b100, 32'hD0D0_0002);

    // Req2 lock: owner idles (nobody granted), then drops lock on 3rd transfer.
    step("lk2 t1", 3'b100, 3'b000, 3'b100, 3'b100, 1'b0, 3'b100, 32'hD0D0_0002);
    step("lk2 idle", 3'b001, 3'b000, 3'b100, 3'b000, 1'b0, 3'b000, 32'hD0D0_0002);
    step("lk2 t2", 3'b101, 3'b000, 3'b100, 3'b100, 1'b0, 3'b100, 32'hD0D0_0002);
    step("lk2 t3", 3'b101, 3'b000, 3'b000, 3'b100, 1'b0, 3'b100, 32'hD0D0_0002);
    step("lk2 after", 3'b111, 3'b000, 3'b000, 3'b001, 1'b0, 3'b001, 32'h1000_000A);

    // Owner drops lock without requesting: lock ends, rr_ptr moves past owner.
    step("lk1b t1", 3'b010, 3'b000, 3'b010, 3'b010, 1'b0, 3'b010, 32'h1000_000B);
    step("lk1b drop", 3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 32'h1000_000B);
    step("lk1b after", 3'b101, 3'b000, 3'b000, 3'b100, 1'b0, 3'b100, 32'hD0D0_0002);

    // Reset while req0 holds a lock.
    step("lk0", 3'b001, 3'b000, 3'b001, 3'b001, 1'b0, 3'b001, 32'h1000_000A);
    i_reset = 1'b1; i_req = 3'b111; i_lock = 3'b001;
    #1;
    chk("rst lock gnt", 32'(o_gnt), 32'h0);
    chk("rst lock wren", 32'(o_mem_wren), 32'h0);
    @(posedge clk); #1;
    chk("rst lock rvalid", 32'(o_rvalid), 32'h0);
    chk("rst lock rdata", o_rdata, 32'h0);
    @(negedge clk);
    i_reset = 1'b0;
    step("post rst", 3'b111, 3'b000, 3'b000, 3'b001, 1'b0, 3'b001, 32'h1000_000A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing one memory port.
REQ-002 Parameter LOCK_MAX, default 8, maximum consecutive locked grants to one requester.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  NREQ  per-requester access request.
REQ-006 i_we  input  NREQ  per-requester write enable; 0 = read.
REQ-007 i_lock  input  NREQ  per-requester hold-grant request for atomic sequences.
REQ-008 i_addr  input  NREQ*9  per-requester word address; slice k = [k*9 +: 9].
REQ-009 i_wdata  input  NREQ*32  per-requester write data; slice k = [k*32 +: 32].
REQ-010 i_bmask  input  NREQ*4  per-requester byte mask; slice k = [k*4 +: 4].
REQ-011 o_gnt  output  NREQ  one-hot or zero grant, combinational.
REQ-012 o_rvalid  output  NREQ  one-hot or zero read-response valid, registered.
REQ-013 o_rdata  output  32  registered read data, shared by all requesters.
REQ-014 o_mem_addr  output  9  address to memory port.
REQ-015 o_mem_wdata  output  32  write data to memory port.
REQ-016 o_mem_bmask  output  4  byte mask to memory port.
REQ-017 o_mem_wren  output  1  write enable to memory port.
REQ-018 i_mem_rdata  input  32  combinational read data from memory port.

Function
REQ-019 Handshake: transfer for requester k occurs in a cycle where i_req[k] and o_gnt[k] are both 1; requester holds req/we/addr/wdata/bmask stable until granted.
REQ-020 At most one o_gnt bit SHALL be 1 per cycle; o_gnt = 0 when i_req = 0.
REQ-021 FSM states IDLE and LOCKED; reset state IDLE.
REQ-022 IDLE: grant goes to first requesting index found scanning from rr_ptr upward, wrapping NREQ-1 -> 0.
REQ-023 On any IDLE transfer by k, rr_ptr <= (k+1) mod NREQ.
REQ-024 IDLE -> LOCKED when transfer by k has i_lock[k] = 1; owner <= k, lock_cnt <= 1.
REQ-025 LOCKED: o_gnt[owner] = i_req[owner]; all other grants 0, even if owner idles.
REQ-026 LOCKED: each owner transfer increments lock_cnt.
REQ-027 LOCKED -> IDLE when owner transfers with i_lock[owner] = 0, or owner drops i_lock with no request; rr_ptr <= (owner+1) mod NREQ.
REQ-028 Forced release: transfer making lock_cnt = LOCK_MAX -> IDLE regardless of i_lock; rr_ptr <= (owner+1) mod NREQ.
REQ-029 Memory outputs are combinational mux of granted slice; o_mem_wren = i_we[g] & transfer; with no transfer, o_mem_addr/wdata/bmask = 0, o_mem_wren = 0.
REQ-030 Write commits at the transfer edge; no write response.
REQ-031 Read transfer by k: o_rdata <= i_mem_rdata and o_rvalid <= one-hot k at that edge; 1-cycle latency.
REQ-032 o_rvalid is a single-cycle pulse; o_rdata holds last read value when o_rvalid = 0.
REQ-033 Write transfer does not assert o_rvalid and does not change o_rdata.
REQ-034 Back-to-back reads from different requesters each return data exactly one cycle after their grant.

Reset
REQ-035 On i_reset = 1 at a clock edge: state IDLE, rr_ptr 0, owner 0, lock_cnt 0, o_rvalid 0, o_rdata 0.
REQ-036 Reset asserted during LOCKED aborts the lock; no transfer in that cycle commits and o_gnt = 0 while i_reset = 1.

Verification
REQ-037 After reset, i_req=3'b111 reads held 3 cycles -> o_gnt 001, 010, 100; o_rvalid same sequence one cycle later.
REQ-038 Req0 write addr 5 wdata 32'hAABBCCDD bmask 4'b0011, then req1 read addr 5 -> o_mem_wren=1, bmask 0011 at write; o_rvalid=010 next cycle, o_rdata = memory word with low half 16'hCCDD.
REQ-039 Req1 transfers with i_lock=1 while req0, req2 request continuously -> only o_gnt=010 for 8 transfers, then forced release, next grant 100.
REQ-040 Req2 locks, then drops i_lock on 3rd transfer -> IDLE after it, next grant to req0 (rr_ptr 0).
REQ-041 i_reset pulsed while LOCKED with req0 owner -> o_gnt=0 during reset; after release with i_req=111, first grant 001, o_rvalid=0, o_rdata=0.
REQ-042 i_req=0 for 5 cycles -> o_gnt 0, o_mem_wren 0, o_rvalid 0, rr_ptr unchanged.
